// File: rtl/function_gen_ctrl.sv
// Sequencer for the DDS waveform generators: latches one configuration per run
// and drives a one-hot enable plus F/P words, with optional linear sweep.
// Define FGEN_PINGPONG_EN for a triangular sweep instead of sawtooth.
module function_gen_ctrl #(
  parameter int unsigned FW      = 8,
  parameter int unsigned PW      = 8,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned NWAVE   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_wave,
  input  logic [FW-1:0]      cfg_f_start,
  input  logic [FW-1:0]      cfg_f_stop,
  input  logic [FW-1:0]      cfg_f_step,
  input  logic [PW-1:0]      cfg_p_word,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_sweep,
  output logic [NWAVE-1:0]   wave_en,
  output logic [FW-1:0]      F_word,
  output logic [PW-1:0]      P_word,
  output logic               busy,
  output logic               sweep_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   settle_q, settle_d;

  logic [1:0]         wave_q, wave_d;
  logic [FW-1:0]      f_start_q, f_start_d;
  logic [FW-1:0]      f_stop_q, f_stop_d;
  logic [FW-1:0]      f_step_q, f_step_d;
  logic [FW-1:0]      f_word_q, f_word_d;
  logic [PW-1:0]      p_word_q, p_word_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               sweep_q, sweep_d;
  logic [NWAVE-1:0]   wave_en_q, wave_en_d;
  logic               sweep_done_q, sweep_done_d;

`ifdef FGEN_PINGPONG_EN
  logic               dir_up_q, dir_up_d;
  logic [FW:0]        nxt_dn;
`endif

  logic               handshake;
  logic               terminal;
  logic [DWELL_W-1:0] dwell_last;
  logic [FW:0]        nxt_up;
  logic [NWAVE-1:0]   wave_onehot;

  assign cfg_ready  = (state_q == S_IDLE) && run_en;
  assign handshake  = cfg_valid && cfg_ready;
  assign busy       = (state_q != S_IDLE);
  assign wave_en    = wave_en_q;
  assign F_word     = f_word_q;
  assign P_word     = p_word_q;
  assign sweep_done = sweep_done_q;

  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
  assign terminal   = (dwell_cnt_q == dwell_last);
  assign nxt_up     = {1'b0, f_word_q} + {1'b0, f_step_q};
`ifdef FGEN_PINGPONG_EN
  assign nxt_dn     = {1'b0, f_word_q} - {1'b0, f_step_q};
`endif

  // Indices at or above NWAVE leave every enable low.
  always_comb begin
    wave_onehot = '0;
    for (int unsigned i = 0; i < NWAVE; i++) begin
      if (32'(wave_q) == i) wave_onehot[i] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (!run_en) begin
      state_d  = S_IDLE;
      settle_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          settle_d = 1'b0;
          if (cfg_valid) state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q) begin
            state_d  = S_RUN;
            settle_d = 1'b0;
          end else begin
            settle_d = 1'b1;
          end
        end
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath logic
  always_comb begin
    wave_d       = wave_q;
    f_start_d    = f_start_q;
    f_stop_d     = f_stop_q;
    f_step_d     = f_step_q;
    f_word_d     = f_word_q;
    p_word_d     = p_word_q;
    dwell_d      = dwell_q;
    dwell_cnt_d  = dwell_cnt_q;
    sweep_d      = sweep_q;
    wave_en_d    = '0;
    sweep_done_d = 1'b0;
`ifdef FGEN_PINGPONG_EN
    dir_up_d     = dir_up_q;
`endif

    if (!run_en || state_q == S_IDLE) begin
      dwell_cnt_d = '0;
`ifdef FGEN_PINGPONG_EN
      dir_up_d    = 1'b1;
`endif
    end

    if (handshake) begin
      wave_d    = cfg_wave;
      f_start_d = cfg_f_start;
      f_stop_d  = cfg_f_stop;
      f_step_d  = cfg_f_step;
      dwell_d   = cfg_dwell;
      sweep_d   = cfg_sweep && (cfg_f_step != '0) && (cfg_f_start < cfg_f_stop);
      f_word_d  = cfg_f_start;
      p_word_d  = cfg_p_word;
    end

    if (run_en && state_q == S_RUN) begin
      wave_en_d = wave_onehot;
      if (sweep_q) begin
        if (terminal) begin
          dwell_cnt_d = '0;
`ifdef FGEN_PINGPONG_EN
          // Landing exactly on an end point turns immediately so no end word repeats.
          if (dir_up_q) begin
            if (nxt_up >= {1'b0, f_stop_q}) begin
              f_word_d = f_stop_q;
              dir_up_d = 1'b0;
            end else begin
              f_word_d = nxt_up[FW-1:0];
            end
          end else begin
            if (nxt_dn[FW] || (nxt_dn[FW-1:0] <= f_start_q)) begin
              f_word_d     = f_start_q;
              dir_up_d     = 1'b1;
              sweep_done_d = 1'b1;
            end else begin
              f_word_d = nxt_dn[FW-1:0];
            end
          end
`else
          if (nxt_up > {1'b0, f_stop_q}) begin
            f_word_d     = f_start_q;
            sweep_done_d = 1'b1;
          end else begin
            f_word_d = nxt_up[FW-1:0];
          end
`endif
        end else begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave_q       <= '0;
      f_start_q    <= '0;
      f_stop_q     <= '0;
      f_step_q     <= '0;
      f_word_q     <= '0;
      p_word_q     <= '0;
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
      sweep_q      <= 1'b0;
      wave_en_q    <= '0;
      sweep_done_q <= 1'b0;
`ifdef FGEN_PINGPONG_EN
      dir_up_q     <= 1'b1;
`endif
    end else begin
      wave_q       <= wave_d;
      f_start_q    <= f_start_d;
      f_stop_q     <= f_stop_d;
      f_step_q     <= f_step_d;
      f_word_q     <= f_word_d;
      p_word_q     <= p_word_d;
      dwell_q      <= dwell_d;
      dwell_cnt_q  <= dwell_cnt_d;
      sweep_q      <= sweep_d;
      wave_en_q    <= wave_en_d;
      sweep_done_q <= sweep_done_d;
`ifdef FGEN_PINGPONG_EN
      dir_up_q     <= dir_up_d;
`endif
    end
  end

endmodule
